// File: rtl/hwpe_tcdm_bridge_package.sv
// Shared types and sizing helpers for the HWPE TCDM flat bridge.
// Optional perf counters are enabled by defining HWPE_TCDM_BRIDGE_PERF_EN.
package hwpe_tcdm_bridge_package;

  localparam int unsigned TCDM_ADDR_WIDTH      = 32;
  localparam int unsigned TCDM_DATA_WIDTH      = 32;
  localparam int unsigned TCDM_BE_WIDTH        = TCDM_DATA_WIDTH / 8;
  localparam int unsigned TCDM_MAX_OUTSTANDING = 4;

  // Request entry layout at the default widths
  typedef struct packed {
    logic [TCDM_ADDR_WIDTH-1:0] add;
    logic                       wen;
    logic [TCDM_BE_WIDTH-1:0]   be;
    logic [TCDM_DATA_WIDTH-1:0] data;
  } tcdm_req_t;

  // Counter width able to hold 0..max_outstanding inclusive
  function automatic int unsigned outstanding_width(input int unsigned max_outstanding);
    return $clog2(max_outstanding + 1);
  endfunction

  localparam int unsigned TCDM_CNT_WIDTH = outstanding_width(TCDM_MAX_OUTSTANDING);

endpackage

// File: rtl/hwpe_tcdm_bridge_fifo.sv
// Synchronous request FIFO with flush; any depth >= 1, no same-cycle bypass.
module hwpe_tcdm_bridge_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full & ~clear;
  assign do_pop   = pop & ~empty & ~clear;
  assign data_out = mem[rd_ptr];

  // Pointer wrap for non-power-of-two depths
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= data_in;
  end

  // Pointer and occupancy tracking; clear overrides push and pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hwpe_tcdm_flat_bridge.sv
// Bridges N_PORTS engine TCDM channels to flat cluster ports with per-port
// request FIFO, outstanding limiter, registered responses and sticky error.
// Define HWPE_TCDM_BRIDGE_PERF_EN to add per-port grant-stall counters.
module hwpe_tcdm_flat_bridge
  import hwpe_tcdm_bridge_package::*;
#(
  parameter int unsigned N_PORTS         = 3,
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned REQ_DEPTH       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   clear,
  input  logic [N_PORTS-1:0]                     eng_req,
  output logic [N_PORTS-1:0]                     eng_gnt,
  input  logic [N_PORTS-1:0][ADDR_WIDTH-1:0]     eng_add,
  input  logic [N_PORTS-1:0]                     eng_wen,
  input  logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]   eng_be,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]     eng_data,
  output logic [N_PORTS-1:0][DATA_WIDTH-1:0]     eng_r_data,
  output logic [N_PORTS-1:0]                     eng_r_valid,
  output logic [N_PORTS-1:0]                     tcdm_req,
  input  logic [N_PORTS-1:0]                     tcdm_gnt,
  output logic [N_PORTS-1:0][ADDR_WIDTH-1:0]     tcdm_add,
  output logic [N_PORTS-1:0]                     tcdm_wen,
  output logic [N_PORTS-1:0][DATA_WIDTH/8-1:0]   tcdm_be,
  output logic [N_PORTS-1:0][DATA_WIDTH-1:0]     tcdm_data,
  input  logic [N_PORTS-1:0][DATA_WIDTH-1:0]     tcdm_r_data,
  input  logic [N_PORTS-1:0]                     tcdm_r_valid,
`ifdef HWPE_TCDM_BRIDGE_PERF_EN
  input  logic                                   perf_clear,
  output logic [N_PORTS-1:0][31:0]               perf_stall,
`endif
  output logic                                   busy,
  output logic [N_PORTS-1:0]                     err
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned ENTRY_W  = ADDR_WIDTH + 1 + BE_WIDTH + DATA_WIDTH;
  localparam int unsigned CNT_W    = outstanding_width(MAX_OUTSTANDING);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] add;
    logic                  wen;
    logic [BE_WIDTH-1:0]   be;
    logic [DATA_WIDTH-1:0] data;
  } entry_t;

  logic [N_PORTS-1:0] queued;
  logic [N_PORTS-1:0] inflight;

  assign busy = (|queued) | (|inflight);

  for (genvar i = 0; i < N_PORTS; i++) begin : g_port
    entry_t                push_entry;
    entry_t                head_entry;
    logic [ENTRY_W-1:0]    head_raw;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [CNT_W-1:0]      cnt;
    logic                  err_q;
    logic                  r_valid_q;
    logic [DATA_WIDTH-1:0] r_data_q;

    assign eng_gnt[i]   = ~full & ~clear;
    assign push         = eng_req[i] & eng_gnt[i];
    assign tcdm_req[i]  = ~empty & (cnt < CNT_W'(MAX_OUTSTANDING)) & ~clear;
    assign pop          = tcdm_req[i] & tcdm_gnt[i];

    assign push_entry   = '{add: eng_add[i], wen: eng_wen[i], be: eng_be[i], data: eng_data[i]};
    assign head_entry   = entry_t'(head_raw);
    assign tcdm_add[i]  = head_entry.add;
    assign tcdm_wen[i]  = head_entry.wen;
    assign tcdm_be[i]   = head_entry.be;
    assign tcdm_data[i] = head_entry.data;

    assign queued[i]      = ~empty;
    assign inflight[i]    = (cnt != '0);
    assign err[i]         = err_q;
    assign eng_r_valid[i] = r_valid_q;
    assign eng_r_data[i]  = r_data_q;

    hwpe_tcdm_bridge_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (REQ_DEPTH)
    ) i_fifo (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .push     (push),
      .data_in  (ENTRY_W'(push_entry)),
      .pop      (pop),
      .data_out (head_raw),
      .full     (full),
      .empty    (empty)
    );

    // Outstanding tracking; a response with nothing in flight flags err and saturates at 0
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt   <= '0;
        err_q <= 1'b0;
      end else begin
        if (tcdm_r_valid[i] && (cnt == '0)) err_q <= 1'b1;
        if (pop && !tcdm_r_valid[i])                     cnt <= cnt + CNT_W'(1);
        else if (!pop && tcdm_r_valid[i] && cnt != '0)   cnt <= cnt - CNT_W'(1);
      end
    end

    // Registered response return; data holds between valid beats
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_valid_q <= 1'b0;
        r_data_q  <= '0;
      end else begin
        r_valid_q <= tcdm_r_valid[i];
        if (tcdm_r_valid[i]) r_data_q <= tcdm_r_data[i];
      end
    end

`ifdef HWPE_TCDM_BRIDGE_PERF_EN
    logic [31:0] stall_q;

    assign perf_stall[i] = stall_q;

    // Saturating count of cycles the cluster withholds grant
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stall_q <= '0;
      end else if (perf_clear) begin
        stall_q <= '0;
      end else if (tcdm_req[i] && !tcdm_gnt[i] && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
`endif
  end

endmodule

// File: tb/tb_hwpe_tcdm_flat_bridge.sv
// Self-checking bench for hwpe_tcdm_flat_bridge: vector table plus corner sequences.
module tb_hwpe_tcdm_flat_bridge;
  import hwpe_tcdm_bridge_package::*;

  localparam int unsigned NP = 3;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  clear;
  logic [NP-1:0]         eng_req, eng_gnt, eng_wen, eng_r_valid;
  logic [NP-1:0][AW-1:0] eng_add, tcdm_add;
  logic [NP-1:0][BW-1:0] eng_be, tcdm_be;
  logic [NP-1:0][DW-1:0] eng_data, eng_r_data, tcdm_data, tcdm_r_data;
  logic [NP-1:0]         tcdm_req, tcdm_gnt, tcdm_wen, tcdm_r_valid;
  logic                  busy;
  logic [NP-1:0]         err;
`ifdef HWPE_TCDM_BRIDGE_PERF_EN
  logic                  perf_clear;
  logic [NP-1:0][31:0]   perf_stall;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int out_model [NP];
  int rsp_seq = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
  } resp_t;
  resp_t sb[$];

  typedef struct {
    int          port;
    tcdm_req_t   req;
    logic [31:0] rdata;
  } vec_t;
  vec_t vecs[5];

  hwpe_tcdm_flat_bridge dut (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .eng_req      (eng_req),
    .eng_gnt      (eng_gnt),
    .eng_add      (eng_add),
    .eng_wen      (eng_wen),
    .eng_be       (eng_be),
    .eng_data     (eng_data),
    .eng_r_data   (eng_r_data),
    .eng_r_valid  (eng_r_valid),
    .tcdm_req     (tcdm_req),
    .tcdm_gnt     (tcdm_gnt),
    .tcdm_add     (tcdm_add),
    .tcdm_wen     (tcdm_wen),
    .tcdm_be      (tcdm_be),
    .tcdm_data    (tcdm_data),
    .tcdm_r_data  (tcdm_r_data),
    .tcdm_r_valid (tcdm_r_valid),
`ifdef HWPE_TCDM_BRIDGE_PERF_EN
    .perf_clear   (perf_clear),
    .perf_stall   (perf_stall),
`endif
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge; response strobes are single-cycle
  task automatic tick();
    @(posedge clk);
    #1;
    tcdm_r_valid = '0;
  endtask

  // Drive one cluster response and record its expected engine-side copy
  task automatic push_resp(input int p, input logic [31:0] d);
    resp_t r;
    tcdm_r_valid[p] = 1'b1;
    tcdm_r_data[p]  = d;
    r.port = p;
    r.data = d;
    sb.push_back(r);
  endtask

  // Grant everything and answer every outstanding request until the port is idle
  task automatic drain(input int p);
    int guard;
    guard = 0;
    eng_req[p]  = 1'b0;
    tcdm_gnt[p] = 1'b1;
    while (guard < 60) begin
      tick();
      if (out_model[p] > 0) begin
        push_resp(p, 32'hD000_0000 + 32'(rsp_seq));
        rsp_seq++;
      end else if (!busy) begin
        break;
      end
      guard++;
    end
    check("drain_done", 64'(guard < 60), 64'd1);
  endtask

  // Scoreboard: track in-flight grants and match every engine response in order
  always @(negedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NP; p++) begin
        int idx;
        if (tcdm_req[p] && tcdm_gnt[p]) out_model[p]++;
        if (tcdm_r_valid[p] && out_model[p] > 0) out_model[p]--;
        if (eng_r_valid[p]) begin
          idx = -1;
          for (int k = 0; k < sb.size(); k++)
            if (idx < 0 && sb[k].port == p) idx = k;
          if (idx < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL resp_unexpected: port %0d data %0h with nothing expected", p, eng_r_data[p]);
          end else begin
            check("resp_data", 64'(eng_r_data[p]), 64'(sb[idx].data));
            sb.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    int grants;
    int pushes;

    vecs[0] = '{port: 0, req: '{add: 32'h0000_1000, wen: 1'b1, be: 4'hF, data: 32'h0}, rdata: 32'hDEAD_BEEF};
    vecs[1] = '{port: 1, req: '{add: 32'h0000_2004, wen: 1'b0, be: 4'h3, data: 32'h1234_5678}, rdata: 32'h0};
    vecs[2] = '{port: 2, req: '{add: 32'hFFFF_FFFC, wen: 1'b1, be: 4'hF, data: 32'h0}, rdata: 32'hA5A5_5A5A};
    vecs[3] = '{port: 0, req: '{add: 32'h0000_0000, wen: 1'b0, be: 4'h8, data: 32'hCAFE_F00D}, rdata: 32'h1};
    vecs[4] = '{port: 2, req: '{add: 32'h8000_0000, wen: 1'b0, be: 4'h0, data: 32'hFFFF_FFFF}, rdata: 32'hFFFF_FFFF};

    rst = 1'b1; clear = 1'b0;
    eng_req = '0; eng_add = '0; eng_wen = '0; eng_be = '0; eng_data = '0;
    tcdm_gnt = '1; tcdm_r_data = '0; tcdm_r_valid = '0;
`ifdef HWPE_TCDM_BRIDGE_PERF_EN
    perf_clear = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_r_valid", 64'(eng_r_valid), 64'd0);
    check("rst_r_data", 64'(eng_r_data), 64'd0);
    check("rst_tcdm_req", 64'(tcdm_req), 64'd0);
    check("rst_eng_gnt", 64'(eng_gnt), 64'h7);

    // Single transactions through each port with the cluster always granting
    for (int v = 0; v < 5; v++) begin
      int p;
      p = vecs[v].port;
      tick();
      eng_req[p] = 1'b1;
      eng_add[p] = vecs[v].req.add; eng_wen[p] = vecs[v].req.wen;
      eng_be[p] = vecs[v].req.be;   eng_data[p] = vecs[v].req.data;
      #2;
      check("vec_eng_gnt", 64'(eng_gnt[p]), 64'd1);
      check("vec_no_early_req", 64'(tcdm_req), 64'd0);
      tick();
      eng_req[p] = 1'b0;
      #2;
      check("vec_tcdm_req", 64'(tcdm_req), 64'(1 << p));
      check("vec_tcdm_add", 64'(tcdm_add[p]), 64'(vecs[v].req.add));
      check("vec_tcdm_wen_be", 64'({tcdm_wen[p], tcdm_be[p]}), 64'({vecs[v].req.wen, vecs[v].req.be}));
      check("vec_tcdm_data", 64'(tcdm_data[p]), 64'(vecs[v].req.data));
      tick();
      push_resp(p, vecs[v].rdata);
      #2;
      check("vec_req_done", 64'(tcdm_req[p]), 64'd0);
      check("vec_busy_inflight", 64'(busy), 64'd1);
      tick();
      #2;
      check("vec_r_valid", 64'(eng_r_valid), 64'(1 << p));
      check("vec_r_data", 64'(eng_r_data[p]), 64'(vecs[v].rdata));
      check("vec_busy_idle", 64'(busy), 64'd0);
      tick();
      #2;
      check("vec_r_valid_low", 64'(eng_r_valid[p]), 64'd0);
      check("vec_r_data_hold", 64'(eng_r_data[p]), 64'(vecs[v].rdata));
    end

    // Backpressure on port 1: two pushes fill the FIFO, head address stays put
    tcdm_gnt[1] = 1'b0;
    pushes = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      eng_req[1] = 1'b1;
      eng_add[1] = 32'h4000 + 32'(16 * c);
      eng_wen[1] = 1'b1;
      #2;
      if (eng_gnt[1]) pushes++;
      if (c > 0) check("bp_head_addr", 64'(tcdm_add[1]), 64'h4000);
    end
    check("bp_pushes", 64'(pushes), 64'd2);
    check("bp_gnt_low", 64'(eng_gnt[1]), 64'd0);
    tick();
    eng_req[1] = 1'b0;
    tcdm_gnt[1] = 1'b1;
    #2;
    check("bp_issue0", 64'({tcdm_req[1], tcdm_add[1]}), {31'd0, 1'b1, 32'h4000});
    tick();
    #2;
    check("bp_issue1", 64'({tcdm_req[1], tcdm_add[1]}), {31'd0, 1'b1, 32'h4010});
    drain(1);

    // Outstanding limit on port 0: four grants, then stall until a response
    grants = 0;
    for (int c = 0; c < 8; c++) begin
      tick();
      eng_req[0] = 1'b1;
      eng_add[0] = 32'h3000 + 32'(4 * c);
      eng_wen[0] = 1'b1;
      #2;
      if (tcdm_req[0] && tcdm_gnt[0]) grants++;
    end
    check("lim_grants", 64'(grants), 64'd4);
    tick();
    eng_req[0] = 1'b0;
    #2;
    check("lim_stalled", 64'(tcdm_req[0]), 64'd0);
    tick();
    push_resp(0, 32'h0BAD_F00D);
    #2;
    check("lim_still_stalled", 64'(tcdm_req[0]), 64'd0);
    tick();
    #2;
    check("lim_resume", 64'(tcdm_req[0]), 64'd1);
    drain(0);

    // Port 1: grant and response together for 10 cycles with 2 in flight
    for (int c = 0; c < 13; c++) begin
      tick();
      eng_req[1] = (c < 12);
      eng_add[1] = 32'h6000 + 32'(4 * c);
      if (c >= 3) push_resp(1, 32'hA000_0000 + 32'(c));
      #2;
      if (c >= 1) check("sim_req", 64'(tcdm_req[1]), 64'd1);
    end
    tick();
    push_resp(1, 32'hB000_0001);
    #2;
    check("sim_busy_2", 64'(busy), 64'd1);
    tick();
    push_resp(1, 32'hB000_0002);
    #2;
    check("sim_busy_1", 64'(busy), 64'd1);
    tick();
    #2;
    check("sim_busy_0", 64'(busy), 64'd0);
    check("sim_err", 64'(err), 64'd0);

    // clear with two queued and one in flight on port 0
    tick();
    eng_req[0] = 1'b1; eng_add[0] = 32'h5000; tcdm_gnt[0] = 1'b1;
    tick();
    eng_add[0] = 32'h5004;
    #2;
    check("clr_first_issue", 64'({tcdm_req[0], tcdm_add[0]}), {31'd0, 1'b1, 32'h5000});
    tick();
    tcdm_gnt[0] = 1'b0; eng_add[0] = 32'h5008;
    #2;
    check("clr_second_push", 64'(eng_gnt[0]), 64'd1);
    tick();
    eng_req[0] = 1'b0;
    #2;
    check("clr_full", 64'({tcdm_req[0], eng_gnt[0], tcdm_add[0]}), {30'd0, 2'b10, 32'h5004});
    clear = 1'b1;
    #1;
    check("clr_gnt_low", 64'(eng_gnt), 64'd0);
    check("clr_req_low", 64'(tcdm_req), 64'd0);
    tick();
    clear = 1'b0;
    #2;
    check("clr_empty", 64'(tcdm_req[0]), 64'd0);
    check("clr_gnt_back", 64'(eng_gnt[0]), 64'd1);
    check("clr_busy_inflight", 64'(busy), 64'd1);
    push_resp(0, 32'h0C1E_A4ED);
    tick();
    #2;
    check("clr_resp", 64'(eng_r_valid[0]), 64'd1);
    check("clr_busy_idle", 64'(busy), 64'd0);
    check("clr_err", 64'(err), 64'd0);
    tcdm_gnt[0] = 1'b1;

    // Spurious response on idle port 2
    tick();
    push_resp(2, 32'h5555_AAAA);
    tick();
    #2;
    check("spur_err", 64'(err), 64'b100);
    check("spur_fwd", 64'(eng_r_valid), 64'b100);
    check("spur_no_underflow", 64'(busy), 64'd0);
    repeat (3) tick();
    #2;
    check("spur_err_sticky", 64'(err), 64'b100);
    check("spur_req_idle", 64'(tcdm_req), 64'd0);

    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
